// File: rtl/cpu_mem_pkg.sv
// Shared memory-side definitions for the CPU data path.
// Default widths/depth and the store-buffer entry layout.
package cpu_mem_pkg;

    localparam int CPU_AW   = 32;
    localparam int CPU_DW   = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [CPU_AW-1:0] addr;
        logic [CPU_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Priority matcher for store-to-load forwarding.
// Returns the youngest valid entry whose address equals the load address.
module store_buffer_fwd
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = CPU_AW,
    parameter int DW    = CPU_DW,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0][AW-1:0] i_addr,
    input  logic [DEPTH-1:0][DW-1:0] i_data,
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [PW-1:0]            i_tail,
    input  logic [AW-1:0]            i_ld_addr,
    output logic                     o_hit,
    output logic [DW-1:0]            o_data
);

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches override.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            logic [PW-1:0] w_idx;
            w_idx = i_tail - PW'(k);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_ld_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between EX/MEM and data memory.
// Drains one store per idle memory cycle and forwards buffered data to loads.
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = CPU_AW,
    parameter int DW    = CPU_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_valid,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    input  logic          mem_busy,
    output logic          mem_write,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    output logic          sb_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_drain;
    logic [DEPTH-1:0]         w_valid;
    logic                     w_fwd_hit;
    logic [DW-1:0]            w_fwd_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Reset forces the idle view on the outputs even if stale state is pending.
    assign st_ready = reset || !w_full;
    assign sb_empty = reset || w_empty;

    assign w_push  = st_valid && !w_full && !reset;
    assign w_drain = !reset && !w_empty && !mem_busy;

    assign mem_write      = w_drain;
    assign mem_address    = r_addr[r_head];
    assign mem_write_data = r_data[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_drain)
                r_head <= r_head + 1'b1;
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

    // Entry i is live when its distance from head is below count.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] w_off;
            w_off      = PW'(i) - r_head;
            w_valid[i] = (CW'(w_off) < r_count);
        end
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_fwd (
        .i_addr    (r_addr),
        .i_data    (r_data),
        .i_valid   (w_valid),
        .i_tail    (r_tail),
        .i_ld_addr (ld_addr),
        .o_hit     (w_fwd_hit),
        .o_data    (w_fwd_data)
    );

    assign ld_hit  = ld_valid && w_fwd_hit && !reset;
    assign ld_data = ld_hit ? w_fwd_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard on the memory write port
// plus per-scenario checks of flow control, forwarding and reset.
module tb_store_buffer;
    import cpu_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic [AW-1:0] ld_addr;
    logic          ld_valid;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_busy;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          sb_empty;

    int tests  = 0;
    int failed = 0;

    sb_entry_t exp_q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_addr        (ld_addr),
        .ld_valid       (ld_valid),
        .ld_hit         (ld_hit),
        .ld_data        (ld_data),
        .mem_busy       (mem_busy),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .sb_empty       (sb_empty)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare each memory write against the oldest accepted store,
    // then record this cycle's accepted store (it lands at the next posedge).
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (mem_write) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_write: unexpected write addr=%0h data=%0h, none expected",
                             mem_address, mem_write_data);
                end else begin
                    sb_entry_t e;
                    e = exp_q.pop_front();
                    if (mem_address !== e.addr || mem_write_data !== e.data) begin
                        failed++;
                        $display("FAIL sb_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                                 mem_address, mem_write_data, e.addr, e.data);
                    end
                end
            end
            if (st_valid && st_ready)
                exp_q.push_back('{addr: st_addr, data: st_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all(input string name);
        int n;
        n = 0;
        st_valid = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk);
        while (!sb_empty && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb_empty !== 1'b1) begin
            failed++;
            $display("FAIL %s_drain_timeout: sb_empty=%b, expected 1", name, sb_empty);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_busy = 1'b0;
        tick(); tick();
        @(negedge clk);
        tests++;
        if ({st_ready, sb_empty, mem_write, ld_hit} !== 4'b1100 || ld_data !== '0) begin
            failed++;
            $display("FAIL reset_outputs: ready=%b empty=%b wr=%b hit=%b ldd=%0h, expected 1 1 0 0 0",
                     st_ready, sb_empty, mem_write, ld_hit, ld_data);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({st_ready, sb_empty, mem_write} !== 3'b110) begin
            failed++;
            $display("FAIL post_reset: ready=%b empty=%b wr=%b, expected 1 1 0", st_ready, sb_empty, mem_write);
        end
        tick();
    endtask

    task automatic test_single();
        mem_busy = 1'b0;
        st_valid = 1'b1; st_addr = 32'd3; st_data = 32'hAAAA_0003;
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b1 || mem_address !== 32'd3 || mem_write_data !== 32'hAAAA_0003) begin
            failed++;
            $display("FAIL single_write: wr=%b addr=%0h data=%0h, expected 1 3 aaaa0003",
                     mem_write, mem_address, mem_write_data);
        end
        tick();
        @(negedge clk);
        tests++;
        if (sb_empty !== 1'b1 || mem_write !== 1'b0) begin
            failed++;
            $display("FAIL single_empty: empty=%b wr=%b, expected 1 0", sb_empty, mem_write);
        end
        tick();
    endtask

    task automatic test_full();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'(i); st_data = 32'h100 + 32'(i);
            @(negedge clk);
            tests++;
            if (st_ready !== 1'b1) begin
                failed++;
                $display("FAIL full_fill_ready: push %0d ready=%b, expected 1", i, st_ready);
            end
            tick();
        end
        st_addr = 32'h9; st_data = 32'h999;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (st_ready !== 1'b0 || mem_write !== 1'b0 || sb_empty !== 1'b0) begin
                failed++;
                $display("FAIL full_refuse: ready=%b wr=%b empty=%b, expected 0 0 0", st_ready, mem_write, sb_empty);
            end
            tick();
        end
        st_valid = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (mem_write !== 1'b1 || mem_address !== 32'(i)) begin
                failed++;
                $display("FAIL full_drain_order: cycle %0d wr=%b addr=%0h, expected 1 %0h", i, mem_write, mem_address, i);
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (sb_empty !== 1'b1) begin
            failed++;
            $display("FAIL full_drained: empty=%b, expected 1", sb_empty);
        end
        tick();
    endtask

    task automatic test_forward();
        logic [AW-1:0] la [5];
        logic          lv [5];
        logic          eh [5];
        logic [DW-1:0] ed [5];
        la = '{32'd5, 32'd7, 32'd6, 32'd5, 32'd0};
        lv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        eh = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ed = '{32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
        mem_busy = 1'b1;
        st_valid = 1'b1; st_addr = 32'd5; st_data = 32'h11; tick();
        st_addr = 32'd5; st_data = 32'h22; tick();
        st_addr = 32'd7; st_data = 32'h33; tick();
        st_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = lv[i]; ld_addr = la[i];
            @(negedge clk);
            tests++;
            if (ld_hit !== eh[i] || ld_data !== ed[i]) begin
                failed++;
                $display("FAIL fwd_lookup: addr=%0h hit=%b data=%0h, expected %b %0h",
                         la[i], ld_hit, ld_data, eh[i], ed[i]);
            end
            tick();
        end
        // Head (addr 5, 0x11) drains this cycle; youngest match still wins.
        mem_busy = 1'b0; ld_valid = 1'b1; ld_addr = 32'd5;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 32'h22) begin
            failed++;
            $display("FAIL fwd_during_drain: wr=%b hit=%b data=%0h, expected 1 1 22", mem_write, ld_hit, ld_data);
        end
        tick();
        ld_valid = 1'b0;
        drain_all("fwd");
    endtask

    task automatic test_back_to_back();
        int accepted;
        int n;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(i); st_data = 32'hB000 + 32'(i);
            tick();
        end
        mem_busy = 1'b0;
        st_addr = 32'h50; st_data = 32'hC000;
        @(negedge clk);
        tests++;
        if (st_ready !== 1'b0 || mem_write !== 1'b1) begin
            failed++;
            $display("FAIL b2b_full_drain: ready=%b wr=%b, expected 0 1", st_ready, mem_write);
        end
        tick();
        @(negedge clk);
        tests++;
        if (st_ready !== 1'b1) begin
            failed++;
            $display("FAIL b2b_accept_next: ready=%b, expected 1", st_ready);
        end
        tick();
        // Ten more pushes with random port contention to exercise pointer wrap.
        accepted = 0; n = 0;
        st_addr = 32'h60; st_data = 32'hD000;
        while (accepted < 10 && n < 60) begin
            mem_busy = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (st_ready) begin
                accepted++;
                tick();
                st_addr = 32'h60 + 32'(accepted); st_data = 32'hD000 + 32'(accepted);
            end else begin
                tick();
            end
            n++;
        end
        tests++;
        if (accepted != 10) begin
            failed++;
            $display("FAIL b2b_push_timeout: accepted=%0d, expected 10", accepted);
        end
        drain_all("b2b");
    endtask

    task automatic test_reset_mid();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h70 + 32'(i); st_data = 32'hE000 + 32'(i);
            tick();
        end
        st_valid = 1'b0; mem_busy = 1'b0; reset = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b0 || sb_empty !== 1'b1) begin
            failed++;
            $display("FAIL rst_mid_cycle: wr=%b empty=%b, expected 0 1", mem_write, sb_empty);
        end
        tick();
        reset = 1'b0; ld_valid = 1'b1; ld_addr = 32'h71;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b0 || sb_empty !== 1'b1 || ld_hit !== 1'b0 || ld_data !== '0) begin
            failed++;
            $display("FAIL rst_mid_after: wr=%b empty=%b hit=%b data=%0h, expected 0 1 0 0",
                     mem_write, sb_empty, ld_hit, ld_data);
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_steady();
        mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st_valid = 1'b1; st_addr = 32'h80 + 32'(i); st_data = 32'hF000 + 32'(i);
            tick();
        end
        mem_busy = 1'b0;
        for (int i = 2; i < 8; i++) begin
            st_valid = 1'b1; st_addr = 32'h80 + 32'(i); st_data = 32'hF000 + 32'(i);
            @(negedge clk);
            tests++;
            if (mem_write !== 1'b1 || st_ready !== 1'b1 || sb_empty !== 1'b0) begin
                failed++;
                $display("FAIL steady_cycle: cycle %0d wr=%b ready=%b empty=%b, expected 1 1 0",
                         i, mem_write, st_ready, sb_empty);
            end
            tick();
        end
        st_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (mem_write !== 1'b1) begin
                failed++;
                $display("FAIL steady_tail: drain %0d wr=%b, expected 1", i, mem_write);
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (sb_empty !== 1'b1) begin
            failed++;
            $display("FAIL steady_count: empty=%b after 2 drains, expected 1", sb_empty);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        test_steady();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL sb_leftover: %0d stores never written, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
